// File: rtl/ws2812_rx.sv
// ws2812_rx: single-wire NRZ LED-stream receiver. It decodes bits from the high-pulse width, assembles GRB MSB-first pixels and marks frames on the latch gap.
// 4 cycles from din falling to valid. A pixel that completes while valid && !ready is dropped and sets the sticky overflow flag. Defining WS2812_RX_COUNT_EN adds px_count.
module ws2812_rx #(
   parameter int unsigned CLK_HZ         = 16000000,
   parameter int unsigned BIT_THRESH_CYC = 9,
   parameter int unsigned MIN_HIGH_CYC   = 3,
   parameter int unsigned MAX_HIGH_CYC   = 40,
   parameter int unsigned RESET_CYC      = 800
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        din,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        valid,
   input  logic        ready,
   output logic        frame_done,
   output logic        overflow,
   output logic        error
`ifdef WS2812_RX_COUNT_EN
   ,output logic [15:0] px_count
`endif
);

   localparam int unsigned LONGEST = (RESET_CYC > MAX_HIGH_CYC) ? RESET_CYC : MAX_HIGH_CYC;
   localparam int unsigned CW      = $clog2(LONGEST + 1);

   localparam logic [1:0] RESYNC = 2'd0;
   localparam logic [1:0] IDLE   = 2'd1;
   localparam logic [1:0] HIGH   = 2'd2;
   localparam logic [1:0] LOW    = 2'd3;

   // All timing is in cycles; the clock frequency only has to be meaningful.
   if (CLK_HZ == 0) begin : g_clk_hz_check
      $error("ws2812_rx: CLK_HZ must be nonzero");
   end

   logic          sync1;
   logic          s_din;
   logic          s_prev;
   logic          rise;
   logic          bit_val;
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [4:0]    bit_cnt;
   logic [23:0]   sr;
   logic          px_done;
`ifdef WS2812_RX_COUNT_EN
   logic [15:0]   px_acc;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1  <= 1'b0;
         s_din  <= 1'b0;
         s_prev <= 1'b0;
      end else begin
         sync1  <= din;
         s_din  <= sync1;
         s_prev <= s_din;
      end
   end

   assign rise    = s_din & ~s_prev;
   assign bit_val = (cnt >= CW'(BIT_THRESH_CYC));

   // cnt holds the high width in HIGH and the low time in RESYNC and LOW.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= RESYNC;
         cnt        <= '0;
         bit_cnt    <= '0;
         sr         <= '0;
         px_done    <= 1'b0;
         frame_done <= 1'b0;
         error      <= 1'b0;
`ifdef WS2812_RX_COUNT_EN
         px_acc     <= '0;
         px_count   <= '0;
`endif
      end else begin
         px_done    <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            RESYNC: begin
               if (s_din) begin
                  cnt <= '0;
               end else if (cnt == CW'(RESET_CYC - 1)) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            IDLE: begin
               if (rise) begin
                  state <= HIGH;
                  cnt   <= CW'(1);
               end
            end
            HIGH: begin
               if (s_din) begin
                  if (cnt == CW'(MAX_HIGH_CYC - 1)) begin
                     error   <= 1'b1;
                     state   <= RESYNC;
                     cnt     <= '0;
                     bit_cnt <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  state <= LOW;
                  cnt   <= CW'(1);
                  if (cnt >= CW'(MIN_HIGH_CYC)) begin
                     sr <= {sr[22:0], bit_val};
                     if (bit_cnt == 5'd23) begin
                        bit_cnt <= '0;
                        px_done <= 1'b1;
`ifdef WS2812_RX_COUNT_EN
                        if (px_acc != 16'hFFFF) px_acc <= px_acc + 1'b1;
`endif
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end
            end
            LOW: begin
               if (rise) begin
                  state <= HIGH;
                  cnt   <= CW'(1);
               end else if (cnt == CW'(RESET_CYC - 1)) begin
                  frame_done <= 1'b1;
                  bit_cnt    <= '0;
                  state      <= IDLE;
                  cnt        <= '0;
`ifdef WS2812_RX_COUNT_EN
                  px_count   <= px_acc;
                  px_acc     <= '0;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= RESYNC;
         endcase
      end
   end

   // A completed pixel loads when the holding register is empty or draining this cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         red      <= '0;
         green    <= '0;
         blue     <= '0;
         valid    <= 1'b0;
         overflow <= 1'b0;
      end else if (px_done) begin
         if (!valid || ready) begin
            green <= sr[23:16];
            red   <= sr[15:8];
            blue  <= sr[7:0];
            valid <= 1'b1;
         end else begin
            overflow <= 1'b1;
         end
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule
